unif_gen: RTL and testbench

UNIF_GEN -- requirements
Module: unif_gen

---
 rtl/unif_gen.sv | 128 ++++++++++++
 tb/tb_unif_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unif_gen.sv
// Uniform random pair generator: 16-bit Galois LFSR draws (d1, d2) and optionally normalizes d1.
// Define UNIF_GEN_NORM_EN to enable the left-shift normalization of d1 (k, sat).
module unif_gen #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
    parameter logic [1:0]  K_MAX        = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        start,
    input  logic        ack,
    output logic [7:0]  d1,
    output logic [1:0]  k,
    output logic [7:0]  d2,
    output logic        valid,
    output logic        busy,
    output logic        sat
);

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned KW     = 2;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

`ifdef UNIF_GEN_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    // With normalization off the shift limit collapses to zero: NORM exits on its first cycle.
    localparam logic [KW-1:0] K_LIM = NORM_EN ? K_MAX : KW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        NORM = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DW-1:0]     d1_q, d1_d;
    logic [DW-1:0]     d2_q, d2_d;
    logic [KW-1:0]     k_q, k_d;
    logic              sat_q, sat_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [LFSR_W-1:0] lfsr_next_c;

    assign lfsr_next_c = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : LFSR_W'(0));

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        k_d     = k_q;
        sat_d   = sat_q;

        if (seed_load) begin
            lfsr_d  = (seed == LFSR_W'(0)) ? SEED_DEFAULT : seed;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_d = DRAW;
                end
                DRAW: begin
                    lfsr_d = lfsr_next_c;
                    d1_d   = lfsr_next_c[DW-1:0];
                    d2_d   = lfsr_next_c[LFSR_W-1:DW];
                    k_d    = KW'(0);
                    sat_d  = 1'b0;
                    if (lfsr_next_c[DW-1:0] != DW'(0)) state_d = NORM;
                end
                NORM: begin
                    if (d1_q[DW-1] || (k_q == K_LIM)) begin
                        state_d = HOLD;
                        sat_d   = NORM_EN && !d1_q[DW-1];
                    end else begin
                        d1_d = {d1_q[DW-2:0], 1'b0};
                        k_d  = k_q + KW'(1);
                    end
                end
                HOLD: begin
                    if (ack) state_d = start ? DRAW : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        valid_d = (state_d == HOLD);
        busy_d  = (state_d == DRAW) || (state_d == NORM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_DEFAULT;
            d1_q    <= '0;
            d2_q    <= '0;
            k_q     <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            k_q     <= k_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign d1    = d1_q;
    assign d2    = d2_q;
    assign k     = k_q;
    assign sat   = sat_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_unif_gen.sv
// Scoreboard bench for unif_gen: a reference LFSR/normalizer predicts each pair and its latency.
module tb_unif_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  d1;
    logic [1:0]  k;
    logic [7:0]  d2;
    logic        valid;
    logic        busy;
    logic        sat;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d1;
        logic [1:0] k;
        logic [7:0] d2;
        logic       sat;
        int         lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_lfsr;

    localparam logic [1:0] K_MAX_TB = 2'd3;
`ifdef UNIF_GEN_NORM_EN
    localparam logic [7:0] A_D1 = 8'hE0;
    localparam logic [1:0] A_K  = 2'd1;
    localparam logic [7:0] C_D1 = 8'h10;
    localparam logic [1:0] C_K  = 2'd3;
    localparam logic       C_SAT = 1'b1;
`else
    localparam logic [7:0] A_D1 = 8'h70;
    localparam logic [1:0] A_K  = 2'd0;
    localparam logic [7:0] C_D1 = 8'h02;
    localparam logic [1:0] C_K  = 2'd0;
    localparam logic       C_SAT = 1'b0;
`endif

    unif_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .ack       (ack),
        .d1        (d1),
        .k         (k),
        .d2        (d2),
        .valid     (valid),
        .busy      (busy),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference draw: advances m_lfsr past zero draws, then normalizes d1.
    function automatic exp_t model_pair();
        exp_t e;
        int   redraws = 0;
        m_lfsr = m_step(m_lfsr);
        while (m_lfsr[7:0] == 8'h00 && redraws < 100) begin
            redraws++;
            m_lfsr = m_step(m_lfsr);
        end
        e.d1  = m_lfsr[7:0];
        e.d2  = m_lfsr[15:8];
        e.k   = 2'd0;
        e.sat = 1'b0;
`ifdef UNIF_GEN_NORM_EN
        while (!e.d1[7] && e.k != K_MAX_TB) begin
            e.d1 = e.d1 << 1;
            e.k  = e.k + 2'd1;
        end
        e.sat = !e.d1[7];
`endif
        e.lat = int'(e.k) + 2 + redraws;
        return e;
    endfunction

    task automatic issue(input logic with_ack);
        start = 1'b1;
        ack   = with_ack;
        sb_q.push_back(model_pair());
        @(posedge clk); #1;
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr    = (s == 16'h0000) ? 16'hACE1 : s;
    endtask

    task automatic wait_pair(input int pre, output exp_t e);
        int n = pre;
        e = '{d1: 8'h00, k: 2'd0, d2: 8'h00, sat: 1'b0, lat: 0};
        total++;
        if (sb_q.size() == 0) begin
            bad++; $display("FAIL sb_empty got=0 want=1 entry");
            return;
        end
        e = sb_q.pop_front();
        do begin
            @(posedge clk); #1;
            n++;
        end while (!valid && n < 60);
        if (!valid) begin bad++; $display("FAIL valid_timeout got=%0d want=%0d", n, e.lat); end
        total++; if (n !== e.lat) begin bad++; $display("FAIL sb_lat got=%0d want=%0d", n, e.lat); end
        total++; if (d1 !== e.d1) begin bad++; $display("FAIL sb_d1 got=%h want=%h", d1, e.d1); end
        total++; if (k !== e.k) begin bad++; $display("FAIL sb_k got=%0d want=%0d", k, e.k); end
        total++; if (d2 !== e.d2) begin bad++; $display("FAIL sb_d2 got=%h want=%h", d2, e.d2); end
        total++; if (sat !== e.sat) begin bad++; $display("FAIL sb_sat got=%b want=%b", sat, e.sat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b want=0", busy); end
    endtask

    task automatic ack_out();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ack_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_busy got=%b want=0", busy); end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({d1, k, d2, valid, busy, sat} !== 21'h0) begin
            bad++;
            $display("FAIL %s got d1=%h k=%0d d2=%h v=%b b=%b s=%b want all 0", tag, d1, k, d2, valid, busy, sat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
        check_zero("post_reset_idle");
    endtask

    task automatic test_default_seed();
        exp_t e;
        issue(1'b0);
        wait_pair(0, e);
        total++; if (d1 !== A_D1) begin bad++; $display("FAIL def_d1 got=%h want=%h", d1, A_D1); end
        total++; if (k !== A_K) begin bad++; $display("FAIL def_k got=%0d want=%0d", k, A_K); end
        total++; if (d2 !== 8'hE2) begin bad++; $display("FAIL def_d2 got=%h want=e2", d2); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL def_sat got=%b want=0", sat); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1 || d1 !== e.d1) begin bad++; $display("FAIL hold_keep got v=%b d1=%h want v=1 d1=%h", valid, d1, e.d1); end
        ack_out();
    endtask

    task automatic test_redraw();
        exp_t e;
        load_seed(16'h0200);
        issue(1'b0);
        wait_pair(0, e);
        total++; if (d1 !== 8'h80 || k !== 2'd0 || d2 !== 8'h00) begin
            bad++; $display("FAIL redraw got d1=%h k=%0d d2=%h want d1=80 k=0 d2=00", d1, k, d2);
        end
        ack_out();
    endtask

    task automatic test_saturate_back_to_back();
        exp_t e;
        load_seed(16'h0004);
        issue(1'b0);
        wait_pair(0, e);
        total++; if (d1 !== C_D1 || k !== C_K || sat !== C_SAT || d2 !== 8'h00) begin
            bad++; $display("FAIL sat_pair got d1=%h k=%0d sat=%b d2=%h want d1=%h k=%0d sat=%b d2=00", d1, k, sat, d2, C_D1, C_K, C_SAT);
        end
        issue(1'b1);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        wait_pair(0, e);
        ack_out();
    endtask

    task automatic test_ignore_inputs();
        exp_t e;
        issue(1'b1);
        start = 1'b1;
        ack   = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        wait_pair(1, e);
        @(posedge clk); #1;
        total++; if (valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL start_in_hold got v=%b b=%b want v=1 b=0", valid, busy); end
        start = 1'b0;
        ack_out();
    endtask

    task automatic test_seed_load_priority();
        exp_t e;
        issue(1'b0);
        wait_pair(0, e);
        seed_load = 1'b1;
        seed      = 16'h0000;
        ack       = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        ack       = 1'b0;
        start     = 1'b0;
        m_lfsr    = 16'hACE1;
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL load_prio got v=%b b=%b want v=0 b=0", valid, busy); end
        total++; if (d1 !== e.d1) begin bad++; $display("FAIL load_keep_d1 got=%h want=%h", d1, e.d1); end
        issue(1'b0);
        wait_pair(0, e);
        total++; if (d1 !== A_D1 || k !== A_K || d2 !== 8'hE2) begin
            bad++; $display("FAIL seed0_pair got d1=%h k=%0d d2=%h want d1=%h k=%0d d2=e2", d1, k, d2, A_D1, A_K);
        end
        ack_out();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_norm");
        sb_q.delete();
        #2;
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
        issue(1'b0);
        wait_pair(0, e);
        total++; if (d1 !== A_D1 || k !== A_K || d2 !== 8'hE2 || sat !== 1'b0) begin
            bad++; $display("FAIL post_reset_pair got d1=%h k=%0d d2=%h sat=%b want d1=%h k=%0d d2=e2 sat=0", d1, k, d2, sat, A_D1, A_K);
        end
        ack_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_default_seed();
        test_redraw();
        test_saturate_back_to_back();
        test_ignore_inputs();
        test_seed_load_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
